stream_fifo_param: RTL
======================

STREAM_FIFO_PARAM -- requirements
Module: stream_fifo_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per word (1..1024).
REQ-002 SHALL have parameter DEPTH, default 288, capacity in words (2..65536); non-power-of-two values are legal.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-16, at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_THRESH, default 16, at or below which almost_empty asserts.
REQ-005 SHALL have ports ap_clk (in, 1, sole clock) and ap_rst (in, 1, synchronous active-high reset).
REQ-006 SHALL have ports maxcount_clr (in, 1, reload high-water mark), count (out, CNT_W, current occupancy), maxcount (out, CNT_W, high-water mark), with CNT_W = clog2(DEPTH+1).
REQ-007 SHALL have ports almost_full (out, 1, count >= AF_THRESH) and almost_empty (out, 1, count <= AE_THRESH).
REQ-008 SHALL have ports in0_V_TDATA (in, WIDTH), in0_V_TVALID (in, 1), in0_V_TREADY (out, 1), forming the AXI-Stream sink.
REQ-009 SHALL have ports out_V_TDATA (out, WIDTH), out_V_TVALID (out, 1), out_V_TREADY (in, 1), forming the AXI-Stream source.

Function
REQ-010 Push SHALL occur on a rising edge where in0_V_TVALID && in0_V_TREADY; pop SHALL occur where out_V_TVALID && out_V_TREADY.
REQ-011 in0_V_TREADY SHALL be registered, equal to (count < DEPTH), with no combinational path from out_V_TREADY; a full FIFO SHALL NOT accept data in a pop cycle.
REQ-012 Output SHALL be first-word-fall-through: a word pushed into an empty FIFO on edge N SHALL drive out_V_TVALID=1 and out_V_TDATA from edge N until popped.
REQ-013 out_V_TDATA SHALL remain stable while out_V_TVALID && !out_V_TREADY; words SHALL leave in push order with none lost or duplicated.
REQ-014 count SHALL include the presented word, increment on push only, decrement on pop only, stay unchanged on simultaneous push and pop, and never exceed DEPTH.
REQ-015 Read and write pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH.
REQ-016 Simultaneous push and pop at count==1 SHALL present the new word on the following cycle with count remaining 1.
REQ-017 almost_full and almost_empty SHALL be registered and consistent with the count value driven in the same cycle.
REQ-018 maxcount SHALL update each edge to max(maxcount, next count); when maxcount_clr=1 it SHALL load next count instead.

Reset
REQ-019 With ap_rst=1 on an edge: count=0, maxcount=0, pointers=0, out_V_TVALID=0, in0_V_TREADY=0, almost_empty=1, almost_full=0; out_V_TDATA is don't-care.
REQ-020 in0_V_TREADY SHALL rise on the first edge with ap_rst=0.
REQ-021 Reset mid-operation SHALL discard all stored words, with no pop or push counted in that cycle.

Configuration
REQ-022 With macro STREAM_FIFO_MAXCOUNT_EN defined, maxcount SHALL behave per REQ-018.
REQ-023 Without STREAM_FIFO_MAXCOUNT_EN, maxcount SHALL be constant 0, maxcount_clr SHALL be ignored, and no high-water register SHALL be synthesised.

Structure
REQ-024 Package stream_fifo_pkg SHALL hold the clog2 width function, default DEPTH/WIDTH constants and a pointer-wrap helper.
REQ-025 Storage SHALL be a sub-module stream_fifo_mem: simple dual-port, one write and one read port, DEPTH x WIDTH, RAM-inferable.
REQ-026 Control, counters, FWFT output register and flags SHALL reside in stream_fifo_param; target size is 120-400 RTL lines.

Verification
REQ-027 Push 288 words 0x00..0x1F wrapping with out_V_TREADY=0 -> in0_V_TREADY=0 after the 288th, count=288, almost_full=1, maxcount=288.
REQ-028 Continue from full: out_V_TREADY=1, in0_V_TVALID=1 -> first pop cycle accepts nothing, then one-in-one-out with count steady at 287.
REQ-029 Single push of 0xA5 into empty FIFO -> out_V_TVALID=1 and out_V_TDATA=0xA5 after the push edge, count=1.
REQ-030 DEPTH=5, 1000 random push/pop cycles against a scoreboard -> order preserved, pointers wrap at 4, count within 0..5.
REQ-031 At maxcount=40, count=10, pulse maxcount_clr -> maxcount=10; build without STREAM_FIFO_MAXCOUNT_EN -> maxcount stays 0.
REQ-032 Assert ap_rst with count=100 -> next cycle count=0, out_V_TVALID=0, in0_V_TREADY=0, then in0_V_TREADY=1 one edge after release.

Source files
------------

// File: rtl/stream_fifo_pkg.sv
// Shared constants and helpers for the parameterised FWFT stream FIFO.
package stream_fifo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 288;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r = 0;
    int unsigned p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Pointer increment that wraps at an arbitrary (non-power-of-two) depth.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read (distributed-RAM style).
module stream_fifo_mem
  import stream_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = clog2(DEPTH)
)(
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stream_fifo_param.sv
// First-word-fall-through AXI-Stream FIFO with occupancy flags and optional high-water mark.
// High-water register is built only when STREAM_FIFO_MAXCOUNT_EN is defined.
module stream_fifo_param
  import stream_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int          AF_THRESH = int'(DEPTH) - 16,
  parameter int          AE_THRESH = 16,
  localparam int unsigned CNT_W    = clog2(DEPTH + 1)
)(
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             maxcount_clr,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] maxcount,
  output logic             almost_full,
  output logic             almost_empty,
  input  logic [WIDTH-1:0] in0_V_TDATA,
  input  logic             in0_V_TVALID,
  output logic             in0_V_TREADY,
  output logic [WIDTH-1:0] out_V_TDATA,
  output logic             out_V_TVALID,
  input  logic             out_V_TREADY
);

  localparam int unsigned PTR_W = clog2(DEPTH);

  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_af;
  logic             r_ae;

  logic             w_push;
  logic             w_pop;
  logic             w_ram_empty;
  logic             w_load;
  logic             w_load_ram;
  logic             w_bypass;
  logic             w_ram_we;
  logic [CNT_W-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_ram_rdata;

  // r_count includes the presented word, so storage is empty when only the output register is full.
  assign w_push      = in0_V_TVALID && r_in_ready;
  assign w_pop       = r_out_valid && out_V_TREADY;
  assign w_ram_empty = (r_count == CNT_W'(r_out_valid));
  assign w_load      = !r_out_valid || w_pop;
  assign w_load_ram  = w_load && !w_ram_empty;
  assign w_bypass    = w_load && w_ram_empty && w_push;
  assign w_ram_we    = w_push && !w_bypass;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  stream_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .i_clk   (ap_clk),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (in0_V_TDATA),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_af        <= 1'b0;
      r_ae        <= 1'b1;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < CNT_W'(DEPTH));
      r_af       <= (int'(32'(w_count_nxt)) >= AF_THRESH);
      r_ae       <= (int'(32'(w_count_nxt)) <= AE_THRESH);
      if (w_ram_we)   r_wr_ptr <= PTR_W'(wrap_inc(32'(r_wr_ptr), DEPTH));
      if (w_load_ram) r_rd_ptr <= PTR_W'(wrap_inc(32'(r_rd_ptr), DEPTH));
      // Output register refills from storage first, else straight from the input when storage is empty.
      if (w_load_ram) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ram_rdata;
      end else if (w_bypass) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in0_V_TDATA;
      end else if (w_load) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef STREAM_FIFO_MAXCOUNT_EN
  logic [CNT_W-1:0] r_maxcount;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_maxcount <= '0;
    end else if (maxcount_clr || (w_count_nxt > r_maxcount)) begin
      r_maxcount <= w_count_nxt;
    end
  end

  assign maxcount = r_maxcount;
`else
  logic w_unused_clr;
  assign w_unused_clr = maxcount_clr;
  assign maxcount     = '0;
`endif

  assign count        = r_count;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign in0_V_TREADY = r_in_ready;
  assign out_V_TVALID = r_out_valid;
  assign out_V_TDATA  = r_out_data;

endmodule
